// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//
// Bundle of every signal between the data-memory arbiter and its neighbours:
// the CPU data port, the ring NIC port, the single-port memory, and the
// conflict counter.
//
//   slave  modport : the arbiter's view (takes requests and memory read data,
//                    drives grants, stalls, read returns and the memory port)
//   master modport : the surrounding system's view (the opposite directions)
//
// Parameters
//   ADDR_W : address width of all ports
//   DATA_W : data width of all ports
//   CNT_W  : width of the conflict counter
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
);
    // CPU data port (requester 0)
    logic              cpu_memEn;
    logic              cpu_memWrEn;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    // Ring NIC port (requester 1)
    logic              nic_req;
    logic              nic_wrEn;
    logic [ADDR_W-1:0] nic_addr;
    logic [DATA_W-1:0] nic_wdata;
    logic              nic_gnt;
    logic [DATA_W-1:0] nic_rdata;
    logic              nic_rvalid;

    // Single-port data memory
    logic              mem_en;
    logic              mem_wrEn;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Performance debug
    logic [CNT_W-1:0]  conflict_cnt;

    modport slave (
        input  cpu_memEn, cpu_memWrEn, cpu_addr, cpu_wdata,
        input  nic_req, nic_wrEn, nic_addr, nic_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall,
        output nic_gnt, nic_rdata, nic_rvalid,
        output mem_en, mem_wrEn, mem_addr, mem_wdata,
        output conflict_cnt
    );

    modport master (
        output cpu_memEn, cpu_memWrEn, cpu_addr, cpu_wdata,
        output nic_req, nic_wrEn, nic_addr, nic_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  nic_gnt, nic_rdata, nic_rvalid,
        input  mem_en, mem_wrEn, mem_addr, mem_wdata,
        input  conflict_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between the CPU data port (requester 0)
// and the ring NIC (requester 1). One access is granted per cycle; when both
// request, the one that did not win last time gets the memory, so sustained
// contention alternates strictly. The loser is stalled and must hold its
// request. Read data comes back from the memory one cycle after the grant and
// is steered to whichever requester issued that read. A saturating counter
// records cycles in which both requesters asked for the memory.
//
// Ports
//   clk   : single clock, all state on the rising edge
//   reset : asynchronous, active-low; clears all state and forces every
//           output to 0 while low
//   bus   : dmem_arbiter_if.slave - CPU, NIC and memory signals plus the
//           conflict counter
//
// Parameters must match those of the connected interface instance.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_NIC = 1'b1
    } owner_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    owner_e            last_q,         last_d;         // last winner
    logic              rd_pend_q,      rd_pend_d;      // read issued last cycle
    owner_e            rd_own_q,       rd_own_d;       // who issued that read
    logic [DATA_W-1:0] cpu_rdata_q,    cpu_rdata_d;    // held CPU load data
    logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic              cpu_req;
    logic              nic_req;
    logic              any_gnt;
    owner_e            winner;
    logic              gnt_wr;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;
    logic              rtn_cpu;
    logic              rtn_nic;

    // Requests are masked while reset is low so that no grant, stall or memory
    // enable can escape during reset, whatever the requesters are driving.
    assign cpu_req = bus.cpu_memEn & reset;
    assign nic_req = bus.nic_req   & reset;

    // -------------------------------------------------------------------------
    // Round-robin arbitration
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block; a path that leaves one unassigned would infer a latch.
    always_comb begin
        any_gnt = 1'b0;
        winner  = OWN_CPU;
        case ({cpu_req, nic_req})
            2'b10: begin
                any_gnt = 1'b1;
                winner  = OWN_CPU;
            end
            2'b01: begin
                any_gnt = 1'b1;
                winner  = OWN_NIC;
            end
            2'b11: begin
                // Whoever did not win last time goes now.
                any_gnt = 1'b1;
                winner  = (last_q == OWN_CPU) ? OWN_NIC : OWN_CPU;
            end
            default: begin
                any_gnt = 1'b0;
                winner  = OWN_CPU;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Memory-port mux: the winner's command, or all zeros when idle
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_wr    = 1'b0;
        gnt_addr  = '0;
        gnt_wdata = '0;
        if (any_gnt) begin
            if (winner == OWN_CPU) begin
                gnt_wr    = bus.cpu_memWrEn;
                gnt_addr  = bus.cpu_addr;
                gnt_wdata = bus.cpu_wdata;
            end else begin
                gnt_wr    = bus.nic_wrEn;
                gnt_addr  = bus.nic_addr;
                gnt_wdata = bus.nic_wdata;
            end
        end
    end

    // A return cycle is the cycle after a granted read; routing depends only
    // on who issued it, not on who is being granted now.
    assign rtn_cpu = rd_pend_q & (rd_own_q == OWN_CPU);
    assign rtn_nic = rd_pend_q & (rd_own_q == OWN_NIC);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        last_d         = last_q;
        rd_pend_d      = 1'b0;
        rd_own_d       = rd_own_q;
        cpu_rdata_d    = cpu_rdata_q;
        conflict_cnt_d = conflict_cnt_q;

        if (any_gnt) begin
            last_d = winner;
        end

        // Writes and idle cycles leave nothing to return next cycle.
        if (any_gnt && !gnt_wr) begin
            rd_pend_d = 1'b1;
            rd_own_d  = winner;
        end

        // Hold the CPU's load data after its return cycle so it stays valid
        // however long the CPU takes to consume it.
        if (rtn_cpu) begin
            cpu_rdata_d = bus.mem_rdata;
        end

        if (cpu_req && nic_req && (conflict_cnt_q != {CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // last_q starts at NIC so the first conflict after reset goes to
            // the CPU.
            last_q         <= OWN_NIC;
            rd_pend_q      <= 1'b0;
            rd_own_q       <= OWN_CPU;
            cpu_rdata_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            last_q         <= last_d;
            rd_pend_q      <= rd_pend_d;
            rd_own_q       <= rd_own_d;
            cpu_rdata_q    <= cpu_rdata_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.mem_en    = any_gnt;
    assign bus.mem_wrEn  = gnt_wr;
    assign bus.mem_addr  = gnt_addr;
    assign bus.mem_wdata = gnt_wdata;

    // A masked request is never granted, so both are 0 while reset is low.
    assign bus.cpu_stall = cpu_req & (winner != OWN_CPU);
    assign bus.nic_gnt   = nic_req & (winner == OWN_NIC);

    // Return-cycle data bypasses the holding register so loads see data with
    // exactly one cycle of latency.
    assign bus.cpu_rdata  = rtn_cpu ? bus.mem_rdata : cpu_rdata_q;
    assign bus.nic_rvalid = rtn_nic;
    assign bus.nic_rdata  = reset ? bus.mem_rdata : '0;

    assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter. A 16-bit-counter instance carries all the
// checks; a second instance with a 4-bit counter receives identical stimulus
// so counter saturation can be observed. A small behavioural memory with
// one-cycle read latency sits on the main instance's memory port.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    localparam logic [63:0] CPU_WORD = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] NIC_WORD = 64'h0000_0000_0000_00AA;
    localparam logic [63:0] WR_WORD  = 64'h0123_4567_89AB_CDEF;

    logic clk;
    logic reset;

    int tests_run;
    int tests_failed;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(16)) bus ();
    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(4))  bus4 ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    // Mirror the main instance's inputs onto the narrow-counter instance.
    assign bus4.cpu_memEn   = bus.cpu_memEn;
    assign bus4.cpu_memWrEn = bus.cpu_memWrEn;
    assign bus4.cpu_addr    = bus.cpu_addr;
    assign bus4.cpu_wdata   = bus.cpu_wdata;
    assign bus4.nic_req     = bus.nic_req;
    assign bus4.nic_wrEn    = bus.nic_wrEn;
    assign bus4.nic_addr    = bus.nic_addr;
    assign bus4.nic_wdata   = bus.nic_wdata;
    assign bus4.mem_rdata   = bus.mem_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory: writes commit at the edge, reads return
    // one cycle later.
    logic [63:0] mem [0:255];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 64'h0;
        mem[8'h20] = NIC_WORD;
    end

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_wrEn) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else              bus.mem_rdata <= mem[bus.mem_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ce, input logic cwr, input logic [31:0] ca,
                         input logic [63:0] cw, input logic nr, input logic nwr,
                         input logic [31:0] na, input logic [63:0] nw);
        bus.cpu_memEn   = ce;
        bus.cpu_memWrEn = cwr;
        bus.cpu_addr    = ca;
        bus.cpu_wdata   = cw;
        bus.nic_req     = nr;
        bus.nic_wrEn    = nwr;
        bus.nic_addr    = na;
        bus.nic_wdata   = nw;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0, 64'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // ---- Reset held low with both requesting ----------------------------
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h10, 64'h0, 1'b1, 1'b0, 32'h20, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en",     bus.mem_en,       64'd0);
        check("rst_cpu_stall",  bus.cpu_stall,    64'd0);
        check("rst_nic_gnt",    bus.nic_gnt,      64'd0);
        check("rst_conflict",   bus.conflict_cnt, 64'd0);
        check("rst_cpu_rdata",  bus.cpu_rdata,    64'd0);
        check("rst_nic_rvalid", bus.nic_rvalid,   64'd0);
        next_cycle();
        reset = 1'b1;

        // ---- CPU only: write then read 0x10 ---------------------------------
        drive(1'b1, 1'b1, 32'h10, CPU_WORD, 1'b0, 1'b0, 32'h0, 64'h0);
        @(negedge clk);
        check("cpu_wr_stall", bus.cpu_stall, 64'd0);
        check("cpu_wr_en",    bus.mem_en,    64'd1);
        check("cpu_wr_wren",  bus.mem_wrEn,  64'd1);
        check("cpu_wr_addr",  bus.mem_addr,  64'h10);
        check("cpu_wr_data",  bus.mem_wdata, CPU_WORD);
        next_cycle();

        drive(1'b1, 1'b0, 32'h10, 64'h0, 1'b0, 1'b0, 32'h0, 64'h0);
        @(negedge clk);
        check("cpu_rd_stall", bus.cpu_stall, 64'd0);
        check("cpu_rd_en",    bus.mem_en,    64'd1);
        check("cpu_rd_wren",  bus.mem_wrEn,  64'd0);
        next_cycle();

        idle();
        @(negedge clk);
        check("cpu_rd_data",   bus.cpu_rdata,  CPU_WORD);
        check("cpu_rd_nic_rv", bus.nic_rvalid, 64'd0);
        check("idle_mem_en",   bus.mem_en,     64'd0);
        next_cycle();

        @(negedge clk);
        check("cpu_rd_hold",   bus.cpu_rdata,    CPU_WORD);
        check("idle_wren",     bus.mem_wrEn,     64'd0);
        check("idle_addr",     bus.mem_addr,     64'd0);
        check("idle_wdata",    bus.mem_wdata,    64'd0);
        check("cpu_only_cnt",  bus.conflict_cnt, 64'd0);
        next_cycle();

        // ---- Reset pulse clears held load data ------------------------------
        reset = 1'b0;
        @(negedge clk);
        check("rst2_cpu_rdata", bus.cpu_rdata, 64'd0);
        next_cycle();
        reset = 1'b1;

        // ---- Contention after reset: both read for 4 cycles -----------------
        drive(1'b1, 1'b0, 32'h10, 64'h0, 1'b1, 1'b0, 32'h20, 64'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("cont%0d_stall", k),  bus.cpu_stall,    64'(k % 2));
            check($sformatf("cont%0d_gnt", k),    bus.nic_gnt,      64'(k % 2));
            check($sformatf("cont%0d_addr", k),   bus.mem_addr,     (k % 2 == 1) ? 64'h20 : 64'h10);
            check($sformatf("cont%0d_rvalid", k), bus.nic_rvalid,   64'(k == 2));
            check($sformatf("cont%0d_cnt", k),    bus.conflict_cnt, 64'(k));
            if (k == 1) check("cont1_cpu_rdata", bus.cpu_rdata, CPU_WORD);
            if (k == 2) check("cont2_nic_rdata", bus.nic_rdata, NIC_WORD);
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("cont4_rvalid",    bus.nic_rvalid,   64'd1);
        check("cont4_nic_rdata", bus.nic_rdata,    NIC_WORD);
        check("cont4_cnt",       bus.conflict_cnt, 64'd4);
        check("cont4_cpu_rdata", bus.cpu_rdata,    CPU_WORD);
        next_cycle();

        // ---- Return overlap: NIC read 0x20, then CPU write 0x30 -------------
        drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 32'h20, 64'h0);
        @(negedge clk);
        check("ovl_nic_gnt", bus.nic_gnt,  64'd1);
        check("ovl_addr",    bus.mem_addr, 64'h20);
        next_cycle();

        drive(1'b1, 1'b1, 32'h30, WR_WORD, 1'b0, 1'b0, 32'h0, 64'h0);
        @(negedge clk);
        check("ovl_rvalid",    bus.nic_rvalid, 64'd1);
        check("ovl_nic_rdata", bus.nic_rdata,  NIC_WORD);
        check("ovl_cpu_stall", bus.cpu_stall,  64'd0);
        check("ovl_wren",      bus.mem_wrEn,   64'd1);
        check("ovl_wr_addr",   bus.mem_addr,   64'h30);
        check("ovl_cpu_rdata", bus.cpu_rdata,  CPU_WORD);
        next_cycle();

        drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 32'h30, 64'h0);
        @(negedge clk);
        check("ovl_rv_clear",  bus.nic_rvalid, 64'd0);
        check("ovl_cpu_hold",  bus.cpu_rdata,  CPU_WORD);
        check("rb_nic_gnt",    bus.nic_gnt,    64'd1);
        next_cycle();

        idle();
        @(negedge clk);
        check("rb_rvalid",     bus.nic_rvalid, 64'd1);
        check("rb_nic_rdata",  bus.nic_rdata,  WR_WORD);
        next_cycle();

        // ---- Reset asserted between a NIC read grant and its return ---------
        drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 32'h20, 64'h0);
        @(negedge clk);
        check("mid_nic_gnt", bus.nic_gnt, 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_en",     bus.mem_en,     64'd0);
        check("mid_rst_gnt",    bus.nic_gnt,    64'd0);
        check("mid_rst_rvalid", bus.nic_rvalid, 64'd0);
        next_cycle();
        reset = 1'b1;
        idle();
        @(negedge clk);
        check("mid_rvalid", bus.nic_rvalid, 64'd0);
        next_cycle();

        // ---- Saturation: 20 conflict cycles ---------------------------------
        drive(1'b1, 1'b0, 32'h10, 64'h0, 1'b1, 1'b0, 32'h20, 64'h0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("sat%0d_cnt16", k), bus.conflict_cnt,  64'(k));
            check($sformatf("sat%0d_cnt4", k),  bus4.conflict_cnt, 64'((k > 15) ? 15 : k));
            check($sformatf("sat%0d_gnt", k),   bus.nic_gnt,       64'(k % 2));
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("sat_final_cnt16", bus.conflict_cnt,  64'd20);
        check("sat_final_cnt4",  bus4.conflict_cnt, 64'd15);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the single-port data memory behind each ring node. Requester 0 is the CPU core's data port (memEn/memWrEn/addr_out/d_out/d_in). Requester 1 is the node's ring network interface (NIC), which deposits and fetches packet payloads. The arbiter grants one access per cycle with round-robin priority, stalls the loser, and routes one-cycle-latency read data back to the requester that issued the read. It also keeps a saturating conflict counter for performance debug.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 64, data width of all ports
- CNT_W, 16, width of conflict counter
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- cpu_memEn  in  1  CPU requests a memory access this cycle
- cpu_memWrEn  in  1  CPU access is a write (valid with cpu_memEn)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data
- cpu_stall  out  1  CPU access not granted this cycle; CPU holds request
- nic_req  in  1  NIC requests a memory access
- nic_wrEn  in  1  NIC access is a write
- nic_addr  in  ADDR_W  NIC address
- nic_wdata  in  DATA_W  NIC write data
- nic_gnt  out  1  NIC access accepted this cycle
- nic_rdata  out  DATA_W  NIC read data, valid when nic_rvalid
- nic_rvalid  out  1  NIC read data valid
- mem_en  out  1  memory enable
- mem_wrEn  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, one cycle after a read enable
- conflict_cnt  out  CNT_W  saturating count of cycles where both requested

## Operation
- State:
  - last_q: last winner, 0=CPU, 1=NIC; reset 1.
  - rd_pend_q: read issued last cycle; reset 0.
  - rd_own_q: owner of that read; reset 0.
  - cpu_rdata_q: reset 0.
  - conflict_cnt: reset 0.
- Grant rules, combinational in the same cycle:
  - Only CPU requests: CPU wins.
  - Only NIC requests: NIC wins.
  - Both request: the winner is the requester that is not last_q.
  - Neither requests: no grant, last_q holds.
- last_q updates to the winner on every cycle in which a grant occurs.
- Memory port:
  - mem_en = 1 when any grant.
  - mem_wrEn, mem_addr and mem_wdata mux from the winner.
  - When idle, mem_wrEn = 0 and mem_addr/mem_wdata = 0.
- Stall and grant outputs:
  - cpu_stall = cpu_memEn & winner≠CPU.
  - nic_gnt = nic_req & winner=NIC.
- Read return:
  - A granted read sets rd_pend_q=1 and rd_own_q=winner. A write or idle cycle clears rd_pend_q.
  - nic_rvalid = rd_pend_q & rd_own_q=NIC.
  - nic_rdata = mem_rdata, passed through unregistered.
  - cpu_rdata = mem_rdata when rd_pend_q & rd_own_q=CPU; otherwise cpu_rdata_q. cpu_rdata_q captures mem_rdata in that return cycle, so the CPU sees stable load data while stalled downstream.
- conflict_cnt increments when cpu_memEn & nic_req. It saturates at 2^CNT_W−1 and never wraps.
- While reset is low, all outputs are 0 regardless of inputs. This includes mem_en, cpu_stall and nic_gnt.

## Timing
- Grant/stall: zero latency, combinational from request inputs and last_q.
- Writes commit at the rising edge that ends the grant cycle.
- Read latency: data is on cpu_rdata/nic_rdata exactly one cycle after the grant cycle.
- Back-to-back reads by the same requester with no contention: one per cycle, full throughput.
- Continuous contention: strict alternation, each requester gets every other cycle, so no starvation.
- A return cycle may coincide with a new grant to either requester; both proceed independently. Return routing depends only on rd_own_q.
- Stalled requester holds its request and address stable; the arbiter does not latch losing requests.
- Reset asserted mid-read clears rd_pend_q, so no rvalid is produced for the pending read.
- The first post-reset conflict goes to the CPU, because last_q resets to 1.

## Test plan
- Reset: hold reset low with both requesting -> mem_en=0, cpu_stall=0, nic_gnt=0, conflict_cnt=0, cpu_rdata=0.
- CPU only:
  - Stimulus: write 0xDEADBEEF00000001 to 0x10, then read 0x10.
  - Required: cpu_stall=0 throughout; mem_wrEn=1 in cycle 1; the cycle after the read, cpu_rdata=0xDEADBEEF00000001.
  - cpu_rdata holds that value after cpu_memEn drops.
- Contention after reset: CPU and NIC both read for 4 cycles.
  - Required grant order: CPU, NIC, CPU, NIC.
  - cpu_stall=0,1,0,1; nic_gnt=0,1,0,1.
  - nic_rvalid high in cycles 3 and 5 only; conflict_cnt=4.
- Return overlap:
  - Stimulus: NIC read 0x20 (memory value 0xAA), then CPU write 0x30 the next cycle.
  - Required: nic_rvalid=1 with nic_rdata=0xAA during the CPU write cycle; cpu_rdata unchanged.
- Reset mid-read: NIC read granted, reset pulsed low before the return edge -> nic_rvalid stays 0.
- Saturation: with CNT_W=4, drive 20 conflict cycles -> conflict_cnt stops at 15.
